// File: rtl/sonar_scan_ctrl.sv
// Sonar scan sequencer: steps the servo, settles, triggers one HC-SR04 measurement
// with timeout, then hands position and distance to the serial transmitter.
module sonar_scan_ctrl #(
    parameter int N_POS       = 8,
    parameter int POS_W       = 3,
    parameter int SETTLE_CYC  = 25_000_000,
    parameter int TIMEOUT_CYC = 2_500_000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ligar,
    input  logic             modo,
    input  logic             fim_medida,
    input  logic [11:0]      medida,
    input  logic             fim_transmissao,
    output logic [POS_W-1:0] posicao,
    output logic             medir,
    output logic             transmitir,
    output logic [POS_W-1:0] tx_posicao,
    output logic [11:0]      tx_medida,
    output logic             erro_timeout,
    output logic             pronto,
    output logic [3:0]       db_estado
);

    typedef enum logic [3:0] {
        INICIAL        = 4'd0,
        POSICIONA      = 4'd1,
        MEDE           = 4'd2,
        AGUARDA_MEDIDA = 4'd3,
        TRANSMITE      = 4'd4,
        AGUARDA_TX     = 4'd5,
        PROXIMA        = 4'd6
    } state_t;

    localparam int SETTLE_LAST  = (SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0;
    localparam int TIMEOUT_LAST = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
    localparam int CNT_MAX      = (SETTLE_CYC > TIMEOUT_CYC) ? SETTLE_CYC : TIMEOUT_CYC;
    localparam int CNT_W        = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [POS_W-1:0] LAST_POS = POS_W'(N_POS - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             dir_down;

    // Settle and timeout never run together, so one counter serves both.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= INICIAL;
            cnt          <= '0;
            dir_down     <= 1'b0;
            posicao      <= '0;
            medir        <= 1'b0;
            transmitir   <= 1'b0;
            tx_posicao   <= '0;
            tx_medida    <= '0;
            erro_timeout <= 1'b0;
            pronto       <= 1'b0;
        end else begin
            medir        <= 1'b0;
            transmitir   <= 1'b0;
            erro_timeout <= 1'b0;
            pronto       <= 1'b0;
            unique case (state)
                INICIAL: begin
                    if (ligar) begin
                        cnt   <= '0;
                        state <= POSICIONA;
                    end
                end
                POSICIONA: begin
                    if (cnt == CNT_W'(SETTLE_LAST)) begin
                        medir <= 1'b1;
                        state <= MEDE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                MEDE: begin
                    cnt   <= '0;
                    state <= AGUARDA_MEDIDA;
                end
                AGUARDA_MEDIDA: begin
                    // A measurement arriving on the timeout cycle still wins.
                    if (fim_medida) begin
                        tx_medida  <= medida;
                        tx_posicao <= posicao;
                        transmitir <= 1'b1;
                        state      <= TRANSMITE;
                    end else if (cnt == CNT_W'(TIMEOUT_LAST)) begin
                        tx_medida    <= 12'hFFF;
                        tx_posicao   <= posicao;
                        erro_timeout <= 1'b1;
                        transmitir   <= 1'b1;
                        state        <= TRANSMITE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                TRANSMITE: begin
                    state <= AGUARDA_TX;
                end
                AGUARDA_TX: begin
                    if (fim_transmissao) begin
                        pronto <= 1'b1;
                        state  <= PROXIMA;
                    end
                end
                PROXIMA: begin
                    cnt <= '0;
                    // Bounce between the end positions without repeating them.
                    if (!modo && N_POS > 1) begin
                        if (!dir_down) begin
                            if (posicao == LAST_POS) begin
                                posicao  <= LAST_POS - POS_W'(1);
                                dir_down <= 1'b1;
                            end else begin
                                posicao <= posicao + POS_W'(1);
                            end
                        end else begin
                            if (posicao == '0) begin
                                posicao  <= POS_W'(1);
                                dir_down <= 1'b0;
                            end else begin
                                posicao <= posicao - POS_W'(1);
                            end
                        end
                    end
                    state <= ligar ? POSICIONA : INICIAL;
                end
                default: state <= INICIAL;
            endcase
        end
    end

    assign db_estado = 4'(state);

endmodule

// File: tb/tb_sonar_scan_ctrl.sv
// Scoreboard bench for sonar_scan_ctrl: driver pushes expected events, monitor pops
// and compares them whenever medir, transmitir, pronto or erro_timeout appear.
module tb_sonar_scan_ctrl;
    localparam int N  = 4;
    localparam int PW = 2;
    localparam int S  = 4;
    localparam int T  = 10;

    logic          clock = 1'b0;
    logic          reset, ligar, modo, fim_medida, fim_transmissao;
    logic [11:0]   medida;
    logic [PW-1:0] posicao, tx_posicao;
    logic          medir, transmitir, erro_timeout, pronto;
    logic [11:0]   tx_medida;
    logic [3:0]    db_estado;

    // kind: 0 = medir, 1 = transmitir, 2 = pronto
    typedef struct {
        int          kind;
        int          cycle;
        int          pos;
        logic [11:0] med;
        bit          err;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   k = 0;
    int   next_medir = 0;
    bit   abort_run = 1'b0;
    logic prev_medir = 1'b0, prev_tx = 1'b0, prev_pronto = 1'b0;

    sonar_scan_ctrl #(.N_POS(N), .POS_W(PW), .SETTLE_CYC(S), .TIMEOUT_CYC(T)) dut (
        .clock(clock), .reset(reset), .ligar(ligar), .modo(modo),
        .fim_medida(fim_medida), .medida(medida), .fim_transmissao(fim_transmissao),
        .posicao(posicao), .medir(medir), .transmitir(transmitir),
        .tx_posicao(tx_posicao), .tx_medida(tx_medida), .erro_timeout(erro_timeout),
        .pronto(pronto), .db_estado(db_estado)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Bounce sweep visiting order: 0,1,..,N-1,N-2,..,1,0,1,...
    function automatic int pos_of(input int kk);
        int per, p;
        if (N == 1) return 0;
        per = 2 * (N - 1);
        p = kk % per;
        return (p < N) ? p : per - p;
    endfunction

    always @(negedge clock) begin
        int   kind;
        exp_t ev;
        if (!reset && (medir || transmitir || pronto || erro_timeout)) begin
            kind = medir ? 0 : transmitir ? 1 : pronto ? 2 : 3;
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_event: kind %0d at cycle %0d, none expected", kind, cyc);
            end else begin
                ev = q.pop_front();
                check("event_kind", kind, ev.kind);
                check("event_cycle", cyc, ev.cycle);
                if (kind == 0 && ev.kind == 0) check("medir_posicao", posicao, ev.pos);
                if (kind == 1 && ev.kind == 1) begin
                    check("tx_posicao", tx_posicao, ev.pos);
                    check("tx_medida", tx_medida, ev.med);
                    check("erro_timeout", erro_timeout, ev.err);
                end
            end
        end
        if (medir) check("medir_single_cycle", prev_medir, 0);
        if (transmitir) check("transmitir_single_cycle", prev_tx, 0);
        if (pronto) check("pronto_single_cycle", prev_pronto, 0);
        prev_medir  <= medir;
        prev_tx     <= transmitir;
        prev_pronto <= pronto;
    end

    // sel: 0 = medir, 1 = transmitir, 2 = pronto; called at a negedge
    task automatic wait_out(input int sel, input int budget);
        int n = 0;
        while (!((sel == 0 && medir) || (sel == 1 && transmitir) || (sel == 2 && pronto))) begin
            if (n == budget) begin
                checks++;
                failures++;
                $display("FAIL wait_pulse_%0d: none within %0d cycles", sel, budget);
                abort_run = 1'b1;
                return;
            end
            n++;
            @(negedge clock);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_posicao"}, posicao, 0);
        check({tag, "_medir"}, medir, 0);
        check({tag, "_transmitir"}, transmitir, 0);
        check({tag, "_tx_posicao"}, tx_posicao, 0);
        check({tag, "_tx_medida"}, tx_medida, 0);
        check({tag, "_erro_timeout"}, erro_timeout, 0);
        check({tag, "_pronto"}, pronto, 0);
        check({tag, "_db_estado"}, db_estado, 0);
    endtask

    task automatic start_scan();
        if (abort_run) return;
        ligar = 1'b1;
        next_medir = cyc + S + 1;
    endtask

    // One full position cycle. d = cycles from medir to fim_medida (d>T: never sent),
    // e = cycles from transmitir to fim_transmissao.
    task automatic run_pos(input int d, input logic [11:0] med, input int e,
                           input bit md, input bit lig_next);
        exp_t x;
        int   m, t;
        bit   acc;
        if (abort_run) return;
        x.kind = 0; x.cycle = next_medir; x.pos = pos_of(k); x.med = '0; x.err = 1'b0;
        q.push_back(x);
        wait_out(0, S + T + 20);
        if (abort_run) return;
        m = cyc;
        modo = md;
        acc = (d >= 1 && d <= T);
        x.kind = 1;
        x.cycle = acc ? m + d + 1 : m + T + 1;
        x.med = acc ? med : 12'hFFF;
        x.err = !acc;
        q.push_back(x);
        if (d <= T) begin
            for (int i = 0; i < d; i++) begin
                medida = 12'($urandom);
                @(negedge clock);
            end
            fim_medida = 1'b1;
            medida = med;
            @(negedge clock);
            fim_medida = 1'b0;
            medida = 12'($urandom);
        end
        wait_out(1, T + 5);
        if (abort_run) return;
        t = cyc;
        ligar = lig_next;
        x.kind = 2; x.cycle = t + e + 1;
        q.push_back(x);
        for (int j = 1; j <= e; j++) begin
            @(negedge clock);
            if (j == 1) check("state_aguarda_tx", db_estado, 5);
            if (j == e) fim_transmissao = 1'b1;
        end
        @(negedge clock);
        fim_transmissao = 1'b0;
        wait_out(2, 4);
        if (abort_run) return;
        if (!md) k++;
        if (lig_next) begin
            next_medir = cyc + S + 1;
        end else begin
            @(negedge clock);
            check("state_inicial_after_stop", db_estado, 0);
        end
    endtask

    task automatic reset_in_wait();
        exp_t x;
        if (abort_run) return;
        start_scan();
        x.kind = 0; x.cycle = next_medir; x.pos = pos_of(k); x.med = '0; x.err = 1'b0;
        q.push_back(x);
        wait_out(0, S + 10);
        if (abort_run) return;
        @(negedge clock);
        @(negedge clock);
        check("state_aguarda_medida", db_estado, 3);
        reset = 1'b1;
        ligar = 1'b0;
        @(negedge clock);
        check_zero("midrun_reset");
        reset = 1'b0;
        k = 0;
        @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; ligar = 1'b0; modo = 1'b0;
        fim_medida = 1'b0; fim_transmissao = 1'b0; medida = '0;
        repeat (3) @(negedge clock);
        check_zero("reset");
        reset = 1'b0;
        @(negedge clock);
        check("idle_without_ligar", db_estado, 0);

        start_scan();
        run_pos(3, 12'h123, 5, 1'b0, 1'b1);
        run_pos($urandom_range(1, T), 12'($urandom), $urandom_range(1, 6), 1'b0, 1'b1);
        run_pos(T + 3, 12'h000, 2, 1'b0, 1'b1);
        run_pos(T, 12'h456, 1, 1'b0, 1'b1);
        run_pos(0, 12'h789, 3, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++)
            run_pos($urandom_range(1, T), 12'($urandom), $urandom_range(1, 6), 1'b0, 1'b1);
        run_pos(2, 12'h222, 2, 1'b1, 1'b1);
        run_pos(4, 12'h333, 3, 1'b1, 1'b1);
        run_pos(6, 12'h444, 4, 1'b1, 1'b0);

        repeat (3) @(negedge clock);
        start_scan();
        for (int i = 0; i < 16; i++)
            run_pos($urandom_range(0, T + 2), 12'($urandom), $urandom_range(1, 6),
                    1'($urandom_range(0, 1)), (i != 15));

        reset_in_wait();
        start_scan();
        run_pos(2, 12'h0AB, 2, 1'b0, 1'b0);

        repeat (5) @(negedge clock);
        check("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
